// File: rtl/switch_allocator_rr_pkg.sv
// Shared sizing for the round-robin switch allocator: port counts, credit width
// and the output-by-input grant matrix type.
package switch_allocator_rr_pkg;
    localparam int SA_N        = 5;
    localparam int SA_M        = 5;
    localparam int SA_CREDIT_W = 4;

    typedef logic [0:SA_M-1][0:SA_N-1] grant_matrix_t;
endpackage

// File: rtl/rr_arbiter_ptr.sv
// Per-output round-robin arbiter: scans upward from a registered pointer and
// moves the pointer past the winner only when a grant is actually taken.
module rr_arbiter_ptr
    import switch_allocator_rr_pkg::*;
#(
    parameter int N = SA_N
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         ce,
    input  logic [0:N-1] req,
    input  logic         enable,
    output logic [0:N-1] grant
);
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_next;

    always_comb begin : scan_p
        int   idx;
        logic found;
        grant    = '0;
        ptr_next = ptr;
        found    = 1'b0;
        idx      = 0;
        if (enable) begin
            for (int k = 0; k < N; k++) begin
                idx = int'(ptr) + k;
                if (idx >= N) begin
                    idx = idx - N;
                end
                if (!found && req[idx]) begin
                    grant[idx] = 1'b1;
                    found      = 1'b1;
                    ptr_next   = (idx == N - 1) ? '0 : PTR_W'(idx + 1);
                end
            end
        end
    end

    // With ce low the pointer freezes, matching the suppressed grant register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (ce) begin
            ptr <= ptr_next;
        end
    end
endmodule

// File: rtl/switch_allocator_rr.sv
// Credit-aware round-robin switch allocator: one arbiter per output, registered
// one-hot grants, and stall flags for outputs blocked by missing downstream credit.
module switch_allocator_rr
    import switch_allocator_rr_pkg::*;
#(
    parameter int N        = SA_N,
    parameter int M        = SA_M,
    parameter int CREDIT_W = SA_CREDIT_W
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          ce,
    input  logic [0:M-1][CREDIT_W-1:0]    i_en,
    input  logic [0:N-1][0:M-1]           i_output_req,
    output logic [0:M-1][0:N-1]           o_output_grant,
    output logic [0:N-1]                  o_input_grant,
    output logic [0:M-1]                  o_data_val,
    output logic [0:M-1]                  o_stall
);
    logic [0:N-1][0:M-1] req_norm;
    logic [0:M-1][0:N-1] req_col;
    logic [0:M-1]        credit_ok;
    logic [0:M-1][0:N-1] arb_grant;
    logic [0:M-1]        stall_next;
    logic [0:M-1][0:N-1] grant_q;
    logic [0:M-1]        stall_q;

    always_comb begin : normalise_p
        logic found;
        req_norm = '0;
        found    = 1'b0;
        for (int n = 0; n < N; n++) begin
            found = 1'b0;
            for (int m = 0; m < M; m++) begin
                if (!found && i_output_req[n][m]) begin
                    req_norm[n][m] = 1'b1;
                    found          = 1'b1;
                end
            end
        end
    end

    // An input popping this cycle still shows the packet in flight, so it sits out.
    always_comb begin
        req_col = '0;
        for (int m = 0; m < M; m++) begin
            for (int n = 0; n < N; n++) begin
                req_col[m][n] = req_norm[n][m] & ~o_input_grant[n];
            end
        end
    end

    // A grant in flight has not yet reduced i_en, so it is charged here.
    always_comb begin : credit_p
        logic [CREDIT_W:0] avail;
        avail     = '0;
        credit_ok = '0;
        for (int m = 0; m < M; m++) begin
            avail        = {1'b0, i_en[m]} - {{CREDIT_W{1'b0}}, |grant_q[m]};
            credit_ok[m] = !avail[CREDIT_W] && (avail != '0);
        end
    end

    for (genvar m = 0; m < M; m++) begin : g_arb
        rr_arbiter_ptr #(.N(N)) u_arb (
            .clk     (clk),
            .reset_n (reset_n),
            .ce      (ce),
            .req     (req_col[m]),
            .enable  (credit_ok[m]),
            .grant   (arb_grant[m])
        );
    end

    always_comb begin
        stall_next = '0;
        for (int m = 0; m < M; m++) begin
            stall_next[m] = (|req_col[m]) & ~credit_ok[m];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || !ce) begin
            grant_q <= '0;
            stall_q <= '0;
        end else begin
            grant_q <= arb_grant;
            stall_q <= stall_next;
        end
    end

    always_comb begin
        o_input_grant = '0;
        o_data_val    = '0;
        for (int m = 0; m < M; m++) begin
            o_data_val[m] = |grant_q[m];
            for (int n = 0; n < N; n++) begin
                o_input_grant[n] = o_input_grant[n] | grant_q[m][n];
            end
        end
    end

    assign o_output_grant = grant_q;
    assign o_stall        = stall_q;
endmodule
